// File: rtl/tick_period_meter_if.sv
// Result bus of tick_period_meter: one held half-period measurement with
// its status flags, plus the consumer's ready.
interface tick_period_meter_if #(
   parameter int CW = 25
);
   logic          meas_valid;
   logic          meas_ready;
   logic [CW-1:0] half_period;
   logic          in_range;
   logic          timeout;
   logic          locked;
   logic          overrun;

   modport master (
      output meas_valid, half_period, in_range, timeout, locked, overrun,
      input  meas_ready
   );

   modport slave (
      input  meas_valid, half_period, in_range, timeout, locked, overrun,
      output meas_ready
   );
endinterface

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures the half-period of a slow asynchronous tick in
// clk_in cycles. Both tick transitions count as edges. Each measurement is
// offered on a valid/ready register together with range, lock, timeout and
// overrun status.
module tick_period_meter #(
   parameter int CW        = 25,
   parameter int EXPECTED  = 25_000_000,
   parameter int TOLERANCE = 250_000,
   parameter int MAX_COUNT = 33_554_431,
   parameter int LOCK_N    = 4
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic                enable,
   input  logic                tick_in,
   tick_period_meter_if.master res
);

   localparam int            LW     = $clog2(LOCK_N + 1);
   localparam logic [CW:0]   EXP_X  = (CW+1)'(EXPECTED);
   localparam logic [CW:0]   TOL_X  = (CW+1)'(TOLERANCE);
   localparam logic [CW-1:0] MAX_C  = CW'(MAX_COUNT);
   localparam logic [LW-1:0] LOCK_C = LW'(LOCK_N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          s1_q, s2_q, s3_q, edge_q;
   logic [CW-1:0] count_q, count_d;
   logic [LW-1:0] lock_q, lock_d;
   logic          tmo_q, tmo_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] hp_q, hp_d;
   logic          inr_q, inr_d;
   logic          ovr_q, ovr_d;
   logic          capture;
   logic          cap_inr;

   // |n - EXPECTED| <= TOLERANCE, evaluated one bit wider so nothing wraps.
   function automatic logic in_window(input logic [CW-1:0] n);
      logic [CW:0] n_x;
      logic [CW:0] diff;
      n_x  = {1'b0, n};
      diff = (n_x >= EXP_X) ? (n_x - EXP_X) : (EXP_X - n_x);
      return (diff <= TOL_X);
   endfunction

   // Two-flop synchronizer, history flop and registered edge pulse (either polarity).
   always_ff @(posedge clk_in) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         s1_q   <= tick_in;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         edge_q <= s2_q ^ s3_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter, lock counter, status flags and the held output result.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         count_q <= '0;
         lock_q  <= '0;
         tmo_q   <= 1'b0;
         valid_q <= 1'b0;
         hp_q    <= '0;
         inr_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         lock_q  <= lock_d;
         tmo_q   <= tmo_d;
         valid_q <= valid_d;
         hp_q    <= hp_d;
         inr_q   <= inr_d;
         ovr_q   <= ovr_d;
      end
   end

   // Next-state logic: measurement FSM, lock tracking and output handshake.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lock_d  = lock_q;
      tmo_d   = tmo_q;
      valid_d = valid_q;
      hp_d    = hp_q;
      inr_d   = inr_q;
      ovr_d   = ovr_q;
      capture = 1'b0;
      cap_inr = in_window(count_q);

      case (state_q)
         IDLE: begin
            count_d = '0;
            if (enable) begin
               state_d = ARM;
            end
         end
         ARM: begin
            if (!enable) begin
               state_d = IDLE;
               count_d = '0;
               lock_d  = '0;
            end else if (edge_q) begin
               // First edge only starts the count; no result comes from it.
               state_d = MEAS;
               count_d = CW'(1);
               tmo_d   = 1'b0;
            end
         end
         MEAS: begin
            if (!enable) begin
               state_d = IDLE;
               count_d = '0;
               lock_d  = '0;
            end else if (edge_q) begin
               capture = 1'b1;
               count_d = CW'(1);
               tmo_d   = 1'b0;
            end else if (count_q == MAX_C) begin
               state_d = ARM;
               count_d = '0;
               lock_d  = '0;
               tmo_d   = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase

      if (capture) begin
         // Lock tracks every capture, including ones dropped by overrun.
         if (cap_inr) begin
            lock_d = (lock_q == LOCK_C) ? lock_q : lock_q + 1'b1;
         end else begin
            lock_d = '0;
         end
         if (!valid_q || res.meas_ready) begin
            valid_d = 1'b1;
            hp_d    = count_q;
            inr_d   = cap_inr;
         end else begin
            ovr_d   = 1'b1;
         end
      end else if (valid_q && res.meas_ready) begin
         valid_d = 1'b0;
      end
   end

   assign res.meas_valid  = valid_q;
   assign res.half_period = hp_q;
   assign res.in_range    = inr_q;
   assign res.timeout     = tmo_q;
   assign res.locked      = (lock_q == LOCK_C);
   assign res.overrun     = ovr_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: directed scenarios plus randomized tick
// traffic, checked every cycle against a timestamp-based reference model.
module tb_tick_period_meter;

   localparam int CW        = 5;
   localparam int EXPECTED  = 10;
   localparam int TOLERANCE = 1;
   localparam int MAX_COUNT = 31;
   localparam int LOCK_N    = 4;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic enable  = 1'b0;
   logic tick_in = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   tick_period_meter_if #(.CW(CW)) bus ();

   tick_period_meter #(
      .CW(CW), .EXPECTED(EXPECTED), .TOLERANCE(TOLERANCE),
      .MAX_COUNT(MAX_COUNT), .LOCK_N(LOCK_N)
   ) dut (
      .clk_in (clk),
      .rst    (rst),
      .enable (enable),
      .tick_in(tick_in),
      .res    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Edges are identified by the sampled tick history; a measurement is the
   // difference of the cycle stamps of two consecutive accepted edges.
   int         cyc = 0;
   logic [3:0] hist = '0;
   int         m_mode = 0;   // 0 idle, 1 waiting for first edge, 2 measuring
   int         m_last = 0;
   int         m_hp = 0;
   int         m_lock = 0;
   bit         m_valid = 0, m_inr = 0, m_tmo = 0, m_ovr = 0;

   task automatic model_step();
      bit e;
      bit cap;
      bit inr;
      int n;
      cyc++;
      cap = 0;
      n   = 0;
      if (rst) begin
         hist = '0; m_mode = 0; m_valid = 0; m_hp = 0; m_inr = 0;
         m_tmo = 0; m_ovr = 0; m_lock = 0;
      end else begin
         e = hist[2] ^ hist[3];
         if (m_mode == 0) begin
            if (enable) m_mode = 1;
         end else if (!enable) begin
            m_mode = 0;
            m_lock = 0;
         end else if (m_mode == 1) begin
            if (e) begin m_mode = 2; m_last = cyc; m_tmo = 0; end
         end else begin
            if (e) begin
               cap = 1; n = cyc - m_last; m_last = cyc; m_tmo = 0;
            end else if (cyc - m_last == MAX_COUNT) begin
               m_tmo = 1; m_lock = 0; m_mode = 1;
            end
         end
         if (cap) begin
            inr = (n >= EXPECTED - TOLERANCE) && (n <= EXPECTED + TOLERANCE);
            m_lock = inr ? ((m_lock < LOCK_N) ? m_lock + 1 : LOCK_N) : 0;
            if (!m_valid || bus.meas_ready) begin
               m_valid = 1; m_hp = n; m_inr = inr;
            end else begin
               m_ovr = 1;
            end
         end else if (m_valid && bus.meas_ready) begin
            m_valid = 0;
         end
         hist = {hist[2:0], tick_in};
      end
   endtask

   function automatic logic [31:0] outs();
      return {22'b0, bus.meas_valid, bus.half_period, bus.in_range,
              bus.timeout, bus.locked, bus.overrun};
   endfunction

   function automatic logic [31:0] model_outs();
      logic [4:0] hp5;
      hp5 = m_hp[4:0];
      return {22'b0, m_valid, hp5, m_inr, m_tmo, (m_lock == LOCK_N), m_ovr};
   endfunction

   always @(posedge clk) model_step();

   always @(negedge clk) chk_eq("cycle", outs(), model_outs());

   // ---------------- stimulus helpers ----------------
   task automatic tog(input int n);
      tick_in = ~tick_in;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      tick_in = 1'b0;
      @(negedge clk);
      chk_eq("reset_state", outs(), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int r;
      bus.meas_ready = 1'b1;
      @(negedge clk);
      chk_eq("reset_state0", outs(), 32'h0);
      enable = 1'b1;
      do_reset();

      // 1: steady 10-cycle half-period, latency and lock
      tog(10);
      tick_in = ~tick_in;
      repeat (3) @(negedge clk);
      chk_eq("t1_lat_pre", bus.meas_valid, 0);
      @(negedge clk);
      chk_eq("t1_lat_valid", bus.meas_valid, 1);
      chk_eq("t1_hp", bus.half_period, 10);
      chk_eq("t1_inr", bus.in_range, 1);
      repeat (6) @(negedge clk);
      tog(10); tog(10);
      tick_in = ~tick_in;
      repeat (3) @(negedge clk);
      chk_eq("t1_lock_pre", bus.locked, 0);
      @(negedge clk);
      chk_eq("t1_locked", bus.locked, 1);
      repeat (6) @(negedge clk);

      // 2: an out-of-range half-period restarts the lock count
      do_reset();
      tog(10); tog(10); tog(10); tog(13);
      tog(4);
      chk_eq("t2_hp13", bus.half_period, 13);
      chk_eq("t2_inr0", bus.in_range, 0);
      chk_eq("t2_nolock", bus.locked, 0);
      repeat (6) @(negedge clk);
      tog(10); tog(10);
      tog(4);
      chk_eq("t2_lock_pre", bus.locked, 0);
      repeat (6) @(negedge clk);
      tog(4);
      chk_eq("t2_locked", bus.locked, 1);
      repeat (6) @(negedge clk);

      // 3: consumer stalls across two captures
      do_reset();
      bus.meas_ready = 1'b0;
      tog(10);
      tog(4);
      chk_eq("t3_first", bus.half_period, 10);
      chk_eq("t3_no_ovr", bus.overrun, 0);
      repeat (5) @(negedge clk);
      tog(4);
      chk_eq("t3_held", bus.half_period, 10);
      chk_eq("t3_ovr", bus.overrun, 1);
      chk_eq("t3_valid", bus.meas_valid, 1);
      repeat (2) @(negedge clk);
      bus.meas_ready = 1'b1;
      @(negedge clk);
      chk_eq("t3_drained", bus.meas_valid, 0);
      repeat (2) @(negedge clk);
      chk_eq("t3_ovr_sticky", bus.overrun, 1);

      // 4: tick stops after lock -> timeout, then re-arm
      do_reset();
      tog(10); tog(10); tog(10); tog(10); tog(10);
      chk_eq("t4_locked", bus.locked, 1);
      repeat (24) @(negedge clk);
      chk_eq("t4_tmo_pre", bus.timeout, 0);
      @(negedge clk);
      chk_eq("t4_tmo", bus.timeout, 1);
      chk_eq("t4_unlock", bus.locked, 0);
      repeat (3) @(negedge clk);
      tick_in = ~tick_in;
      repeat (3) @(negedge clk);
      chk_eq("t4_tmo_hold", bus.timeout, 1);
      @(negedge clk);
      chk_eq("t4_tmo_clr", bus.timeout, 0);
      chk_eq("t4_no_result", bus.meas_valid, 0);
      repeat (6) @(negedge clk);
      tog(4);
      chk_eq("t4_rearm_hp", bus.half_period, 10);
      chk_eq("t4_rearm_valid", bus.meas_valid, 1);
      repeat (6) @(negedge clk);

      // 5: enable gap mid-measurement with a pending result
      do_reset();
      tog(10); tog(10); tog(10); tog(10); tog(5);
      bus.meas_ready = 1'b0;
      repeat (5) @(negedge clk);
      tog(4);
      chk_eq("t5_pending", bus.meas_valid, 1);
      chk_eq("t5_locked", bus.locked, 1);
      @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      tog(5);
      chk_eq("t5_gap_unlock", bus.locked, 0);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      chk_eq("t5_still_valid", bus.meas_valid, 1);
      chk_eq("t5_still_hp", bus.half_period, 10);
      bus.meas_ready = 1'b1;
      @(negedge clk);
      chk_eq("t5_taken", bus.meas_valid, 0);
      tog(4);
      chk_eq("t5_no_span", bus.meas_valid, 0);
      repeat (6) @(negedge clk);
      tog(4);
      chk_eq("t5_new_hp", bus.half_period, 10);
      chk_eq("t5_new_lock", bus.locked, 0);
      repeat (6) @(negedge clk);

      // 6: reset while valid and locked, then 9 / 11
      do_reset();
      tog(10); tog(10); tog(10); tog(5);
      bus.meas_ready = 1'b0;
      repeat (5) @(negedge clk);
      tog(4);
      chk_eq("t6_pre_valid", bus.meas_valid, 1);
      chk_eq("t6_pre_lock", bus.locked, 1);
      do_reset();
      bus.meas_ready = 1'b1;
      tog(9);
      tog(4);
      chk_eq("t6_hp9", bus.half_period, 9);
      chk_eq("t6_inr9", bus.in_range, 1);
      repeat (7) @(negedge clk);
      tog(4);
      chk_eq("t6_hp11", bus.half_period, 11);
      chk_eq("t6_inr11", bus.in_range, 1);
      repeat (6) @(negedge clk);

      // Randomized traffic: jittered periods, minimum periods, stalls,
      // timeouts, enable gaps and resets.
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         bus.meas_ready = ($urandom_range(0, 3) != 0);
         if (r < 3) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else if (r < 8) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            enable = 1'b1;
         end else if (r < 13) begin
            tog($urandom_range(30, 40));
         end else if (r < 25) begin
            tog($urandom_range(1, 2));
         end else begin
            tog($urandom_range(8, 13));
         end
      end

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
